// File: rtl/aes_cipher_sequencer.sv
// aes_cipher_sequencer: sequences start/clear requests to the AES cipher core and tracks register-side flags
module aes_cipher_sequencer #(
  parameter bit STALL_ON_UNREAD = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       op_i,
  input  logic       manual_start_i,
  input  logic       start_trig_i,
  input  logic       key_clear_trig_i,
  input  logic       data_out_clear_trig_i,
  input  logic [7:0] key_we_i,
  input  logic [3:0] data_in_we_i,
  input  logic [3:0] data_out_re_i,
  output logic       cipher_in_valid_o,
  input  logic       cipher_in_ready_i,
  input  logic       cipher_out_valid_i,
  output logic       cipher_out_ready_o,
  output logic       cipher_start_o,
  output logic       cipher_dec_key_gen_o,
  output logic       cipher_key_clear_o,
  output logic       cipher_data_out_clear_o,
  output logic       start_ack_o,
  output logic       key_clear_ack_o,
  output logic       data_out_clear_ack_o,
  output logic       data_out_we_o,
  output logic       data_out_clr_o,
  output logic       output_valid_o,
  output logic       stall_o,
  output logic       idle_o
);
  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_e;
  state_e     state_q;
  logic       key_new_q, dec_key_gen_q, key_clr_q, dout_clr_q;
  logic [3:0] data_in_new_q, data_out_read_q;
  logic       clr_req, start_req, accept, out_hs, capture, key_new_clr, din_clr;
  // request decode, handshakes and flag-clear events
  always_comb begin
    clr_req     = key_clear_trig_i | data_out_clear_trig_i;
    start_req   = manual_start_i ? start_trig_i : &data_in_new_q;
    accept      = (state_q == IDLE) & cipher_in_valid_o & cipher_in_ready_i;
    stall_o     = (state_q == BUSY) & STALL_ON_UNREAD & output_valid_o & ~dec_key_gen_q;
    cipher_out_ready_o = (state_q == BUSY) ? ~stall_o : (state_q == CLEAR);
    out_hs      = cipher_out_valid_i & cipher_out_ready_o;
    capture     = (state_q == BUSY) & out_hs & ~dec_key_gen_q;
    key_new_clr = out_hs & ((state_q == BUSY) ? dec_key_gen_q : (state_q == CLEAR) & key_clr_q);
    din_clr     = accept & cipher_start_o & ~cipher_dec_key_gen_o;
    idle_o      = (state_q == IDLE) & ~cipher_in_valid_o;
  end
  // sequencer FSM with registered cipher controls, pulses and register-side flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q                 <= IDLE;
      key_new_q               <= 1'b0;
      dec_key_gen_q           <= 1'b0;
      key_clr_q               <= 1'b0;
      dout_clr_q              <= 1'b0;
      data_in_new_q           <= '0;
      data_out_read_q         <= '0;
      cipher_in_valid_o       <= 1'b0;
      cipher_start_o          <= 1'b0;
      cipher_dec_key_gen_o    <= 1'b0;
      cipher_key_clear_o      <= 1'b0;
      cipher_data_out_clear_o <= 1'b0;
      start_ack_o             <= 1'b0;
      key_clear_ack_o         <= 1'b0;
      data_out_clear_ack_o    <= 1'b0;
      data_out_we_o           <= 1'b0;
      data_out_clr_o          <= 1'b0;
      output_valid_o          <= 1'b0;
    end else begin
      start_ack_o          <= 1'b0;
      key_clear_ack_o      <= 1'b0;
      data_out_clear_ack_o <= 1'b0;
      data_out_we_o        <= 1'b0;
      data_out_clr_o       <= 1'b0;
      key_new_q            <= (|key_we_i) | (key_new_q & ~key_new_clr);
      data_in_new_q        <= data_in_we_i | (data_in_new_q & {4{~din_clr}});
      data_out_read_q      <= capture ? 4'h0 : (data_out_read_q | data_out_re_i);
      if (&data_out_read_q) output_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!cipher_in_valid_o) begin
            if (clr_req) begin
              cipher_in_valid_o       <= 1'b1;
              cipher_start_o          <= 1'b0;
              cipher_dec_key_gen_o    <= 1'b0;
              cipher_key_clear_o      <= key_clear_trig_i;
              cipher_data_out_clear_o <= data_out_clear_trig_i;
            end else if (start_req) begin
              cipher_in_valid_o       <= 1'b1;
              cipher_start_o          <= 1'b1;
              cipher_dec_key_gen_o    <= op_i & key_new_q;
              cipher_key_clear_o      <= 1'b0;
              cipher_data_out_clear_o <= 1'b0;
            end
          end else if (cipher_in_ready_i) begin
            cipher_in_valid_o       <= 1'b0;
            cipher_start_o          <= 1'b0;
            cipher_dec_key_gen_o    <= 1'b0;
            cipher_key_clear_o      <= 1'b0;
            cipher_data_out_clear_o <= 1'b0;
            if (cipher_start_o) begin
              dec_key_gen_q <= cipher_dec_key_gen_o;
              start_ack_o   <= ~cipher_dec_key_gen_o;
              state_q       <= BUSY;
            end else begin
              key_clr_q            <= cipher_key_clear_o;
              dout_clr_q           <= cipher_data_out_clear_o;
              key_clear_ack_o      <= cipher_key_clear_o;
              data_out_clear_ack_o <= cipher_data_out_clear_o;
              state_q              <= CLEAR;
            end
          end
        end
        BUSY: begin
          if (out_hs) begin
            state_q       <= IDLE;
            dec_key_gen_q <= 1'b0;
            if (!dec_key_gen_q) begin
              data_out_we_o  <= 1'b1;
              output_valid_o <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (cipher_out_valid_i) begin
            state_q    <= IDLE;
            key_clr_q  <= 1'b0;
            dout_clr_q <= 1'b0;
            if (dout_clr_q) begin
              data_out_clr_o <= 1'b1;
              output_valid_o <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_cipher_sequencer.sv
// tb_aes_cipher_sequencer: directed plus randomized checks of the cipher sequencer against a flag-level model
module tb_aes_cipher_sequencer;
  logic       clk_i = 1'b0, rst_ni = 1'b0;
  logic       op_i = 1'b0, manual_start_i = 1'b0, start_trig_i = 1'b0;
  logic       key_clear_trig_i = 1'b0, data_out_clear_trig_i = 1'b0;
  logic [7:0] key_we_i = '0;
  logic [3:0] data_in_we_i = '0, data_out_re_i = '0;
  logic       cipher_in_ready_i = 1'b0, cipher_out_valid_i = 1'b0;
  logic       cipher_in_valid_o, cipher_out_ready_o, cipher_start_o, cipher_dec_key_gen_o;
  logic       cipher_key_clear_o, cipher_data_out_clear_o;
  logic       start_ack_o, key_clear_ack_o, data_out_clear_ack_o;
  logic       data_out_we_o, data_out_clr_o, output_valid_o, stall_o, idle_o;
  int         checks = 0, failures = 0;
  bit         m_key_new = 0, m_out_valid = 0, d;
  logic [3:0] m_read = '0;

  aes_cipher_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i), .manual_start_i(manual_start_i),
    .start_trig_i(start_trig_i), .key_clear_trig_i(key_clear_trig_i),
    .data_out_clear_trig_i(data_out_clear_trig_i), .key_we_i(key_we_i),
    .data_in_we_i(data_in_we_i), .data_out_re_i(data_out_re_i),
    .cipher_in_valid_o(cipher_in_valid_o), .cipher_in_ready_i(cipher_in_ready_i),
    .cipher_out_valid_i(cipher_out_valid_i), .cipher_out_ready_o(cipher_out_ready_o),
    .cipher_start_o(cipher_start_o), .cipher_dec_key_gen_o(cipher_dec_key_gen_o),
    .cipher_key_clear_o(cipher_key_clear_o), .cipher_data_out_clear_o(cipher_data_out_clear_o),
    .start_ack_o(start_ack_o), .key_clear_ack_o(key_clear_ack_o),
    .data_out_clear_ack_o(data_out_clear_ack_o), .data_out_we_o(data_out_we_o),
    .data_out_clr_o(data_out_clr_o), .output_valid_o(output_valid_o),
    .stall_o(stall_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid;
    for (int i = 0; i < 20 && cipher_in_valid_o !== 1'b1; i++) tick();
    chk("in_valid_timeout", cipher_in_valid_o, 1);
  endtask

  task automatic write_data;
    logic [3:0] cov, m;
    cov = '0;
    while (cov != 4'hF) begin
      m = 4'($urandom_range(1, 15));
      data_in_we_i = m;
      cov |= m;
      tick();
    end
    data_in_we_i = '0;
  endtask

  task automatic write_key;
    key_we_i = 8'($urandom_range(1, 255));
    tick();
    key_we_i = '0;
    m_key_new = 1;
  endtask

  task automatic serve(output bit was_dkg);
    bit exp_dkg, exp_stall, s_op;
    int n;
    wait_valid();
    exp_dkg = op_i & m_key_new;
    chk("start", cipher_start_o, 1);
    chk("dec_key_gen", cipher_dec_key_gen_o, exp_dkg);
    chk("not_idle", idle_o, 0);
    s_op = op_i;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      op_i = ~op_i;
      tick();
      chk("hold_start", cipher_start_o, 1);
      chk("hold_dkg", cipher_dec_key_gen_o, exp_dkg);
    end
    op_i = s_op;
    cipher_in_ready_i = 1;
    tick();
    cipher_in_ready_i = 0;
    chk("start_ack", start_ack_o, !exp_dkg);
    chk("valid_drop", cipher_in_valid_o, 0);
    if (!exp_dkg) start_trig_i = 0;
    exp_stall = m_out_valid && !exp_dkg;
    chk("stall", stall_o, exp_stall);
    chk("out_ready", cipher_out_ready_o, !exp_stall);
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) tick();
    cipher_out_valid_i = 1;
    if (exp_dkg) begin
      tick();
      cipher_out_valid_i = 0;
      chk("dkg_no_we", data_out_we_o, 0);
      m_key_new = 0;
    end else begin
      if (exp_stall) begin
        tick();
        chk("stalled_no_we", data_out_we_o, 0);
        chk("stall_held", stall_o, 1);
        data_out_re_i = ~m_read;
        tick();
        data_out_re_i = '0;
        m_read = 4'hF;
      end
      for (int i = 0; i < 8 && data_out_we_o !== 1'b1; i++) tick();
      cipher_out_valid_i = 0;
      chk("capture_we", data_out_we_o, 1);
      chk("out_valid_set", output_valid_o, 1);
      m_out_valid = 1;
      m_read = '0;
    end
    was_dkg = exp_dkg;
  endtask

  task automatic read_some;
    logic [3:0] m;
    m = 4'($urandom);
    if (m != 0) begin
      data_out_re_i = m;
      tick();
      data_out_re_i = '0;
      m_read |= m;
    end
    tick();
    if (m_read == 4'hF) m_out_valid = 0;
    chk("out_valid_after_read", output_valid_o, m_out_valid);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_idle", idle_o, 1);
    chk("rst_in_valid", cipher_in_valid_o, 0);
    chk("rst_start", cipher_start_o, 0);
    chk("rst_out_ready", cipher_out_ready_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_out_valid", output_valid_o, 0);
    chk("rst_we", data_out_we_o, 0);
    chk("rst_acks", {start_ack_o, key_clear_ack_o, data_out_clear_ack_o}, 0);
    rst_ni = 1;
    tick();
    // auto-mode encrypt, then no restart since the input words were consumed
    write_data();
    serve(d);
    repeat (3) tick();
    chk("auto_no_restart", idle_o, 1);
    // second result while first is unread: stalls until all words read
    write_data();
    serve(d);
    // manual decrypt with a fresh key: key-gen pass first, then the real pass
    manual_start_i = 1;
    op_i = 1;
    write_key();
    write_data();
    repeat (3) tick();
    chk("manual_waits", idle_o, 1);
    start_trig_i = 1;
    serve(d);
    chk("dkg_first_pass", d, 1);
    serve(d);
    chk("dkg_second_pass", d, 0);
    // start and key clear together: clear is served first
    write_key();
    start_trig_i = 1;
    key_clear_trig_i = 1;
    wait_valid();
    chk("clr_start", cipher_start_o, 0);
    chk("clr_key", cipher_key_clear_o, 1);
    chk("clr_dout", cipher_data_out_clear_o, 0);
    cipher_in_ready_i = 1;
    tick();
    cipher_in_ready_i = 0;
    chk("key_clear_ack", key_clear_ack_o, 1);
    chk("no_start_ack_on_clear", start_ack_o, 0);
    chk("no_dout_ack", data_out_clear_ack_o, 0);
    key_clear_trig_i = 0;
    chk("clear_out_ready", cipher_out_ready_o, 1);
    cipher_out_valid_i = 1;
    tick();
    cipher_out_valid_i = 0;
    chk("key_clear_no_dclr", data_out_clr_o, 0);
    m_key_new = 0;
    serve(d);
    chk("post_clear_no_dkg", d, 0);
    // data-out clear with a valid result
    chk("pre_dclr_valid", output_valid_o, m_out_valid);
    data_out_clear_trig_i = 1;
    wait_valid();
    chk("dclr_flag", cipher_data_out_clear_o, 1);
    chk("dclr_key_flag", cipher_key_clear_o, 0);
    cipher_in_ready_i = 1;
    tick();
    cipher_in_ready_i = 0;
    chk("dclr_ack", data_out_clear_ack_o, 1);
    data_out_clear_trig_i = 0;
    cipher_out_valid_i = 1;
    tick();
    cipher_out_valid_i = 0;
    chk("dclr_pulse", data_out_clr_o, 1);
    chk("dclr_out_valid", output_valid_o, 0);
    m_out_valid = 0;
    tick();
    chk("dclr_pulse_end", data_out_clr_o, 0);
    chk("dclr_idle", idle_o, 1);
    // reset during BUSY abandons the transaction
    manual_start_i = 0;
    op_i = 0;
    write_data();
    wait_valid();
    cipher_in_ready_i = 1;
    tick();
    cipher_in_ready_i = 0;
    rst_ni = 0;
    #1;
    chk("midrst_idle", idle_o, 1);
    chk("midrst_ack", start_ack_o, 0);
    cipher_out_valid_i = 1;
    tick();
    chk("midrst_no_we", data_out_we_o, 0);
    chk("midrst_out_valid", output_valid_o, 0);
    cipher_out_valid_i = 0;
    rst_ni = 1;
    m_key_new = 0;
    m_out_valid = 0;
    m_read = '0;
    repeat (3) tick();
    chk("midrst_stays_idle", idle_o, 1);
    // randomized auto-mode traffic
    for (int it = 0; it < 16; it++) begin
      op_i = 1'($urandom);
      if ($urandom_range(0, 1) == 1) write_key();
      write_data();
      serve(d);
      if (d) serve(d);
      read_some();
      repeat (2) tick();
      chk("rand_idle", idle_o, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_cipher_sequencer.md
AES_CIPHER_SEQUENCER -- requirements
Module: aes_cipher_sequencer

Interface
REQ-001 SHALL have parameter STALL_ON_UNREAD, default 1: when 1, a new result is not accepted from the cipher while the previous output is unread.
REQ-002 SHALL have ports clk_i in 1 (clock) and rst_ni in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have ports:
 op_i in 1 (0=encrypt, 1=decrypt)
 manual_start_i in 1 (1=start only on trigger)
 start_trig_i in 1
 key_clear_trig_i in 1
 data_out_clear_trig_i in 1
REQ-004 SHALL have register-strobe ports:
 key_we_i in 8 (per-word key writes)
 data_in_we_i in 4 (per-word input writes)
 data_out_re_i in 4 (per-word output reads)
REQ-005 SHALL have cipher-side ports:
 cipher_in_valid_o out 1
 cipher_in_ready_i in 1
 cipher_out_valid_i in 1
 cipher_out_ready_o out 1
 cipher_start_o out 1
 cipher_dec_key_gen_o out 1
 cipher_key_clear_o out 1
 cipher_data_out_clear_o out 1
REQ-006 SHALL have status/control outputs, each 1 bit:
 start_ack_o, key_clear_ack_o, data_out_clear_ack_o (single-cycle trigger-clear pulses)
 data_out_we_o (capture cipher result)
 data_out_clr_o (zero output registers)
 output_valid_o
 stall_o
 idle_o

Function
REQ-007 SHALL implement FSM states IDLE, BUSY, CLEAR; encodings other than these return to IDLE on the next clock.
REQ-008 SHALL track key_new_q (set by any key_we_i bit), data_in_new_q[3:0] (bit set by data_in_we_i) and data_out_read_q[3:0] (bit set by data_out_re_i).
REQ-009 IDLE, request priority: (1) clear if key_clear_trig_i|data_out_clear_trig_i; (2) start if (manual_start_i ? start_trig_i : data_in_new_q==4'hF).
REQ-010 IDLE clear request: cipher_in_valid_o=1, cipher_start_o=0, cipher_key_clear_o=key_clear_trig_i, cipher_data_out_clear_o=data_out_clear_trig_i. On cipher_in_ready_i: pulse the matching *_ack_o, latch both flags, go to CLEAR.
REQ-011 IDLE start request: cipher_in_valid_o=1, cipher_start_o=1, cipher_dec_key_gen_o=(op_i & key_new_q). On cipher_in_ready_i: latch dec_key_gen_q and go to BUSY.
REQ-012 Start acceptance without dec-key-gen SHALL clear data_in_new_q and pulse start_ack_o; acceptance with dec-key-gen SHALL do neither, so the pending start reissues afterwards.
REQ-013 Cipher control outputs SHALL be held stable while cipher_in_valid_o=1 and cipher_in_ready_i=0.
REQ-014 BUSY: stall_o = STALL_ON_UNREAD & output_valid_o & ~dec_key_gen_q; cipher_out_ready_o = ~stall_o.
REQ-015 BUSY completion, on cipher_out_valid_i & cipher_out_ready_o, go to IDLE and:
 dec_key_gen_q=1: clear key_new_q only.
 dec_key_gen_q=0: pulse data_out_we_o, set output_valid_o, clear data_out_read_q.
REQ-016 CLEAR: cipher_out_ready_o=1. On cipher_out_valid_i, go to IDLE and:
 data-out flag: pulse data_out_clr_o, clear output_valid_o.
 key flag: clear key_new_q.
REQ-017 output_valid_o SHALL clear the cycle after data_out_read_q reaches 4'hF.
REQ-018 Simultaneous events:
 data_in_we_i bit vs clear-on-accept in the same cycle: the write wins.
 data_out_re_i vs capture in the same cycle: the capture wins (read bits cleared).
 key_we_i vs key_new_q clear in the same cycle: the set wins.
REQ-019 Trigger inputs arriving outside IDLE SHALL be ignored until IDLE; triggers are level-held by the register block until *_ack_o.
REQ-020 idle_o=1 iff state is IDLE and cipher_in_valid_o=0.

Reset
REQ-021 Reset SHALL force state IDLE and zero all flags and registered outputs, giving idle_o=1 and every other output 0. Reset mid-operation SHALL abandon the transaction without any ack or data_out_we_o pulse.

Verification
REQ-022 Auto mode encrypt: write 4 data words, cipher_in_ready_i=1 -> cipher_start_o with cipher_dec_key_gen_o=0, start_ack_o pulse, data_in_new_q=0. cipher_out_valid_i -> data_out_we_o pulse, output_valid_o=1.
REQ-023 Decrypt with new key, op_i=1, manual start -> first transaction has cipher_dec_key_gen_o=1 and no ack. After completion key_new_q=0, then a second transaction with cipher_dec_key_gen_o=0 and start_ack_o.
REQ-024 Stall: STALL_ON_UNREAD=1, output unread, second op completes -> stall_o=1, cipher_out_ready_o=0. Read all 4 words -> stall_o=0 and the result is captured.
REQ-025 start_trig_i and key_clear_trig_i together -> clear served first (cipher_key_clear_o=1); start issues after return to IDLE.
REQ-026 data_out_clear_trig_i with output_valid_o=1 -> CLEAR, data_out_clr_o pulse, output_valid_o=0. Assert rst_ni low during BUSY -> idle_o=1, no data_out_we_o pulse.
